bsg_front_side_bus_hop_out_no_fc: RTL
=====================================

Name: bsg_front_side_bus_hop_out_no_fc

Overview:
Egress side of a front-side-bus hop and the counterpart of the hop-in stage. Merges upstream through-traffic with locally injected packets onto the single outgoing bus segment toward the next hop.
- Through-traffic has no flow control and always wins arbitration.
- Local traffic is buffered in a small FIFO with a valid/ready handshake and drains only in idle bus slots.
- Output is fully registered, so the segment-to-segment timing is one flop.

Parameters:
width_p, 32, bus payload width in bits
local_fifo_els_p, 2, local FIFO depth; power of two, >= 2

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_i  in  1  synchronous, active-high reset
through_data_i  in  width_p  payload from upstream hop-in
through_v_i  in  1  upstream payload valid; cannot be stalled
local_data_i  in  width_p  payload from local node
local_v_i  in  1  local payload valid
local_ready_o  out  1  local FIFO can accept this cycle
data_o  out  width_p  registered bus payload to next hop
v_o  out  1  registered bus valid to next hop
stall_cnt_o  out  16  local-blocked cycle count; 0 when feature compiled out

Behaviour:
- Reset (reset_i high at a rising edge):
  - v_o=0, FIFO emptied, stall_cnt_o=0.
  - data_o is not reset and is meaningful only when v_o=1.
  - local_ready_o=0 in any cycle where reset_i=1.
- Local enqueue: occurs when local_v_i & local_ready_o.
  - local_ready_o = ~full & ~reset_i, derived from registered occupancy only.
  - No same-cycle bypass when full: a dequeue in the same cycle does not open a slot.
- Arbitration each cycle:
  - If through_v_i=1: next v_o=1, next data_o=through_data_i; the FIFO head stays in place.
  - Else if FIFO non-empty: next v_o=1, next data_o=FIFO head, and the head is dequeued.
  - Else: next v_o=0, and data_o holds its previous value.
- Latency:
  - through_v_i to v_o is exactly 1 cycle.
  - Local accept to earliest v_o is 2 cycles. An enqueue into an empty FIFO is not visible to the arbiter until the next cycle.
- Ordering: local packets leave in FIFO order. Through packets are never reordered, dropped, or delayed beyond 1 cycle.
- FIFO pointers: read and write pointers are log2(local_fifo_els_p) bits and wrap naturally. Occupancy is tracked with one extra bit. Simultaneous enqueue and dequeue leaves occupancy unchanged.
- Full: local_ready_o=0; local_v_i is ignored with no state change.
- Empty with no through traffic: v_o deasserts on the next cycle.
- Reset mid-operation: all buffered local packets are discarded, and any in-flight registered output is invalidated (v_o=0 next cycle).
- Starvation: continuous through traffic may starve local traffic indefinitely; this is by design, since upstream has no flow control.

Optional Feature:
Macro BSG_FSB_HOP_OUT_STALL_CNT_EN.
- Defined: a 16-bit saturating counter increments each cycle with FIFO non-empty & through_v_i=1. It holds at 16'hFFFF, clears on reset, and drives stall_cnt_o.
- Undefined: no counter flops are built; stall_cnt_o is tied to 16'h0000.

Decomposition:
- Shared package bsg_fsb_pkg holds:
  - constant for the stall-counter width (16);
  - localparam helper for the FIFO pointer width.
- One natural sub-module, bsg_front_side_bus_hop_out_fifo: parameterized 1-read/1-write FIFO with registered storage, full/empty flags, and no bypass.
- The top level contains the arbiter, the output registers, and the optional counter.

Test Plan:
- Reset held 3 cycles while both inputs are driven valid -> v_o=0 and local_ready_o=0 throughout; stall_cnt_o=0 after release.
- through_v_i=1 with data 32'hDEADBEEF for one cycle, FIFO empty -> next cycle v_o=1, data_o=32'hDEADBEEF; following cycle v_o=0.
- Local injects 32'h11, 32'h22 back-to-back with no through traffic:
  - local_ready_o stays 1 on both accepts;
  - data_o=32'h11 two cycles after the first accept, then 32'h22; v_o drops after.
- Fill FIFO (2 entries) while through_v_i=1 for 10 cycles:
  - local_ready_o=0 once full;
  - v_o carries only through data;
  - with the macro defined, stall_cnt_o=9 at the end of the burst (not counted on the enqueue cycle of the first entry);
  - local entries emerge in order once through_v_i drops.
- Full FIFO with local_v_i=1 held and a dequeue this cycle -> no enqueue that cycle; enqueue occurs the next cycle; no packet lost or duplicated.
- Assert reset_i with 2 local entries buffered and v_o=1 -> v_o=0 next cycle, buffered entries never appear, and local_ready_o=1 the first cycle after reset deasserts.

Source files
------------

// File: rtl/bsg_fsb_pkg.sv
// Shared constants and helpers for the front-side-bus hop blocks.
package bsg_fsb_pkg;

  // Width of the local-blocked stall counter exposed on stall_cnt_o.
  localparam int stall_cnt_width_lp = 16;

  // Pointer width for a power-of-two FIFO with els entries.
  function automatic int fifo_ptr_width(input int els);
    return $clog2(els);
  endfunction

endpackage

// File: rtl/bsg_front_side_bus_hop_out_no_fc_if.sv
// Bus bundle for the front-side-bus hop-out stage.
//
// Valid/ready semantics:
// - through_v_i has no ready; a through payload is consumed in the cycle
//   it is valid.
// - A local payload transfers on a rising edge where local_v_i and
//   local_ready_o are both 1. local_ready_o depends only on registered
//   occupancy and reset_i, never on local_v_i.
// - v_o/data_o have no backpressure; data_o is meaningful only when v_o=1.
interface bsg_front_side_bus_hop_out_no_fc_if
  import bsg_fsb_pkg::*;
#(
  parameter int width_p = 32
);
  logic [width_p-1:0]            through_data_i;
  logic                          through_v_i;
  logic [width_p-1:0]            local_data_i;
  logic                          local_v_i;
  logic                          local_ready_o;
  logic [width_p-1:0]            data_o;
  logic                          v_o;
  logic [stall_cnt_width_lp-1:0] stall_cnt_o;

  // Upstream/local node side.
  modport master (
    output through_data_i, through_v_i, local_data_i, local_v_i,
    input  local_ready_o, data_o, v_o, stall_cnt_o
  );

  // Hop-out stage side.
  modport slave (
    input  through_data_i, through_v_i, local_data_i, local_v_i,
    output local_ready_o, data_o, v_o, stall_cnt_o
  );
endinterface

// File: rtl/bsg_front_side_bus_hop_out_fifo.sv
// 1-read/1-write FIFO with registered storage and no bypass. A write into
// an empty FIFO becomes visible at the head on the following cycle, and a
// read in the same cycle as a full condition does not free a slot early.
module bsg_front_side_bus_hop_out_fifo
  import bsg_fsb_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = fifo_ptr_width(els_p);
  localparam logic [ptr_w_lp:0] els_lp = (ptr_w_lp + 1)'(els_p);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [ptr_w_lp:0]   occ_r;
  logic                full, empty, enq, deq;

  assign full    = (occ_r == els_lp);
  assign empty   = (occ_r == '0);
  assign ready_o = ~full & ~reset_i;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & ~empty;
  assign v_o     = ~empty;
  assign data_o  = mem_r[rd_ptr_r];

  // Pointers wrap naturally; occupancy carries one extra bit to tell full from empty.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (enq) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (deq) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({enq, deq})
        2'b10:   occ_r <= occ_r + 1'b1;
        2'b01:   occ_r <= occ_r - 1'b1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Storage is not reset; entries are only read when occupancy says valid.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= data_i;
  end
endmodule

// File: rtl/bsg_front_side_bus_hop_out_no_fc.sv
// Front-side-bus hop-out: merges unstallable through-traffic with buffered
// local traffic onto one fully registered outgoing segment. Through-traffic
// always wins; local packets drain only in idle slots.
// Optional: BSG_FSB_HOP_OUT_STALL_CNT_EN builds a 16-bit saturating count
// of cycles where local traffic waited behind through-traffic.
module bsg_front_side_bus_hop_out_no_fc
  import bsg_fsb_pkg::*;
#(
  parameter int width_p          = 32,
  parameter int local_fifo_els_p = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  bsg_front_side_bus_hop_out_no_fc_if.slave bus
);
  logic               fifo_v;
  logic               fifo_yumi;
  logic [width_p-1:0] fifo_data;
  logic               v_r;
  logic [width_p-1:0] data_r;

  // Local head is taken only when no through packet claims the slot.
  assign fifo_yumi = ~bus.through_v_i & fifo_v;

  bsg_front_side_bus_hop_out_fifo #(
    .width_p (width_p),
    .els_p   (local_fifo_els_p)
  ) local_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (bus.local_data_i),
    .v_i     (bus.local_v_i),
    .ready_o (bus.local_ready_o),
    .data_o  (fifo_data),
    .v_o     (fifo_v),
    .yumi_i  (fifo_yumi)
  );

  // Output valid: any source present this cycle; cleared by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) v_r <= 1'b0;
    else         v_r <= bus.through_v_i | fifo_v;
  end

  // Output payload: through first, then FIFO head, else hold.
  always_ff @(posedge clk_i) begin
    if (bus.through_v_i) data_r <= bus.through_data_i;
    else if (fifo_v)     data_r <= fifo_data;
  end

  assign bus.v_o    = v_r;
  assign bus.data_o = data_r;

`ifdef BSG_FSB_HOP_OUT_STALL_CNT_EN
  logic [stall_cnt_width_lp-1:0] stall_cnt_r;

  // Count cycles where a buffered local packet lost to through-traffic; saturates.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      stall_cnt_r <= '0;
    else if (fifo_v & bus.through_v_i & ~(&stall_cnt_r))
      stall_cnt_r <= stall_cnt_r + 1'b1;
  end

  assign bus.stall_cnt_o = stall_cnt_r;
`else
  assign bus.stall_cnt_o = stall_cnt_width_lp'(0);
`endif
endmodule
